// File: rtl/tx_code_group_sequencer_if.sv
// Code-group sequencer bus: ordered-set request and data in, octet stream and
// ordered-set status out. Clock and reset stay as plain ports on the design.
interface tx_code_group_sequencer_if;
   logic [2:0]  tx_o_set;
   logic [7:0]  TXD;
   logic [15:0] tx_config_reg;
   logic        rd_pos;
   logic [7:0]  tx_octet;
   logic        tx_is_k;
   logic        tx_even;
   logic        TX_OSET_indicate;
   logic        align_err;

   // requester / ordered-set machine side
   modport master (
      output tx_o_set, TXD, tx_config_reg, rd_pos,
      input  tx_octet, tx_is_k, tx_even, TX_OSET_indicate, align_err
   );

   // sequencer side
   modport slave (
      input  tx_o_set, TXD, tx_config_reg, rd_pos,
      output tx_octet, tx_is_k, tx_even, TX_OSET_indicate, align_err
   );
endinterface

// File: rtl/tx_code_group_sequencer.sv
// PCS transmit code-group sequencer: expands ordered-set requests into one
// K/D-tagged octet per GTX_CLK, tracks even/odd slot and end-of-set.
module tx_code_group_sequencer #(
   parameter bit CFG_ALTERNATE = 1'b1
) (
   input  logic                        GTX_CLK,
   input  logic                        mr_main_reset,
   tx_code_group_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {IDLE_TEST, I_1B, I_2B, C_A, C_B, C_C, C_D, SINGLE} state_t;

   localparam logic [2:0] OS_I = 3'd0, OS_C = 3'd1, OS_S = 3'd2, OS_T = 3'd3,
                          OS_R = 3'd4, OS_D = 3'd6;

   localparam logic [7:0] K28_5 = 8'hBC, K27_7 = 8'hFB, K29_7 = 8'hFD,
                          K23_7 = 8'hF7, K30_7 = 8'hFE, D5_6  = 8'hC5,
                          D16_2 = 8'h50, D21_5 = 8'hB5, D2_2  = 8'h42;

   state_t      state_q, state_d;
   logic [7:0]  octet_q, octet_d;
   logic        k_q, k_d;
   logic        even_q, even_d;
   logic        ind_q, ind_d;
   logic        aerr_q, aerr_d;
   logic [15:0] cfg_q, cfg_d;
   logic        alt_q, alt_d;   // 0 = next /C/ uses C1, 1 = C2
   logic        rdp_q, rdp_d;   // rd_pos captured at the /I/ K28.5 edge
   logic [2:0]  sel;

   // next-state and next-output: mid-set states walk their code groups,
   // set-boundary states (IDLE_TEST, I_2B, C_D, SINGLE) sample a new request
   always_comb begin
      state_d = state_q;
      octet_d = octet_q;
      k_d     = 1'b1;
      even_d  = ~even_q;
      ind_d   = 1'b0;
      aerr_d  = 1'b0;
      cfg_d   = cfg_q;
      alt_d   = alt_q;
      rdp_d   = rdp_q;
      sel     = bus.tx_o_set;
      unique case (state_q)
         I_1B: begin
            state_d = I_2B;
            octet_d = rdp_q ? D5_6 : D16_2;
            k_d     = 1'b0;
            ind_d   = 1'b1;
         end
         C_A: begin
            state_d = C_B;
            octet_d = alt_q ? D2_2 : D21_5;
            k_d     = 1'b0;
            alt_d   = CFG_ALTERNATE ? ~alt_q : 1'b0;
         end
         C_B: begin
            state_d = C_C;
            octet_d = cfg_q[7:0];
            k_d     = 1'b0;
         end
         C_C: begin
            state_d = C_D;
            octet_d = cfg_q[15:8];
            k_d     = 1'b0;
            ind_d   = 1'b1;
         end
         default: begin
            // first set after reset is always /I/
            sel     = (state_q == IDLE_TEST) ? OS_I : bus.tx_o_set;
            state_d = SINGLE;
            ind_d   = 1'b1;
            alt_d   = 1'b0;
            // even_q=1 means the slot being filled now is odd
            if ((sel == OS_I || sel == OS_C) && even_q) begin
               octet_d = K30_7;
               aerr_d  = 1'b1;
            end else begin
               unique case (sel)
                  OS_I: begin
                     state_d = I_1B;
                     octet_d = K28_5;
                     ind_d   = 1'b0;
                     rdp_d   = bus.rd_pos;
                  end
                  OS_C: begin
                     state_d = C_A;
                     octet_d = K28_5;
                     ind_d   = 1'b0;
                     cfg_d   = bus.tx_config_reg;
                     alt_d   = alt_q;
                  end
                  OS_S:    octet_d = K27_7;
                  OS_T:    octet_d = K29_7;
                  OS_R:    octet_d = K23_7;
                  OS_D: begin
                     octet_d = bus.TXD;
                     k_d     = 1'b0;
                  end
                  default: octet_d = K30_7;   // /V/ and reserved
               endcase
            end
         end
      endcase
   end

   // state and output registers; reset aborts any set in progress
   always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
      if (!mr_main_reset) begin
         state_q <= IDLE_TEST;
         octet_q <= 8'h00;
         k_q     <= 1'b0;
         even_q  <= 1'b0;
         ind_q   <= 1'b0;
         aerr_q  <= 1'b0;
         cfg_q   <= 16'h0000;
         alt_q   <= 1'b0;
         rdp_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         octet_q <= octet_d;
         k_q     <= k_d;
         even_q  <= even_d;
         ind_q   <= ind_d;
         aerr_q  <= aerr_d;
         cfg_q   <= cfg_d;
         alt_q   <= alt_d;
         rdp_q   <= rdp_d;
      end
   end

   assign bus.tx_octet         = octet_q;
   assign bus.tx_is_k          = k_q;
   assign bus.tx_even          = even_q;
   assign bus.TX_OSET_indicate = ind_q;
   assign bus.align_err        = aerr_q;

endmodule

// File: tb/tb_tx_code_group_sequencer.sv
// Bench for the code-group sequencer: directed scenarios then random
// requests, compared against a queue-based ordered-set model.
module tb_tx_code_group_sequencer;

   logic GTX_CLK = 1'b0;
   logic mr_main_reset = 1'b0;

   tx_code_group_sequencer_if bus ();

   tx_code_group_sequencer #(.CFG_ALTERNATE(1'b1)) dut (
      .GTX_CLK       (GTX_CLK),
      .mr_main_reset (mr_main_reset),
      .bus           (bus)
   );

   always #5 GTX_CLK = ~GTX_CLK;

   typedef struct {
      logic [7:0] o;
      logic       k;
      logic       ind;
   } cg_t;

   cg_t  mq[$];     // code groups of the set in flight
   bit   first;     // next set is the forced post-reset /I/
   int   slot;      // code groups emitted since reset release
   bit   tog;       // 1 = next /C/ is C2
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (slot %0d)", tag, obs, exp, slot);
      end
   endtask

   function automatic cg_t mk(input logic [7:0] o, input logic k, input logic ind);
      cg_t c;
      c.o = o; c.k = k; c.ind = ind;
      return c;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, ".octet"}, bus.tx_octet, 8'h00);
      chk({tag, ".k"},     bus.tx_is_k, 1'b0);
      chk({tag, ".even"},  bus.tx_even, 1'b0);
      chk({tag, ".ind"},   bus.TX_OSET_indicate, 1'b0);
      chk({tag, ".aerr"},  bus.align_err, 1'b0);
   endtask

   // assert reset now (asynchronously), hold 2 edges, release on a falling edge
   task automatic do_reset();
      mr_main_reset = 1'b0;
      #1 chk_zero("rst_now");
      repeat (2) @(posedge GTX_CLK);
      #1 chk_zero("rst_hold");
      @(negedge GTX_CLK);
      mr_main_reset = 1'b1;
      mq.delete();
      first = 1'b1;
      slot  = 0;
      tog   = 1'b0;
   endtask

   // one clock: drive request, let the model build the set at a boundary, compare
   task automatic step(input logic [2:0] os, input logic [7:0] d,
                       input logic [15:0] cfg, input logic rd);
      cg_t e;
      bit  e_aerr;
      int  s;
      bus.tx_o_set = os; bus.TXD = d; bus.tx_config_reg = cfg; bus.rd_pos = rd;
      @(posedge GTX_CLK);
      e_aerr = 1'b0;
      if (mq.size() == 0) begin
         s = first ? 0 : int'(os);
         first = 1'b0;
         if ((s == 0 || s == 1) && (slot % 2 == 1)) begin
            mq.push_back(mk(8'hFE, 1'b1, 1'b1));
            e_aerr = 1'b1;
            tog = 1'b0;
         end else begin
            case (s)
               0: begin
                  mq.push_back(mk(8'hBC, 1'b1, 1'b0));
                  mq.push_back(mk(rd ? 8'hC5 : 8'h50, 1'b0, 1'b1));
                  tog = 1'b0;
               end
               1: begin
                  mq.push_back(mk(8'hBC, 1'b1, 1'b0));
                  mq.push_back(mk(tog ? 8'h42 : 8'hB5, 1'b0, 1'b0));
                  mq.push_back(mk(cfg[7:0], 1'b0, 1'b0));
                  mq.push_back(mk(cfg[15:8], 1'b0, 1'b1));
                  tog = ~tog;
               end
               2: begin mq.push_back(mk(8'hFB, 1'b1, 1'b1)); tog = 1'b0; end
               3: begin mq.push_back(mk(8'hFD, 1'b1, 1'b1)); tog = 1'b0; end
               4: begin mq.push_back(mk(8'hF7, 1'b1, 1'b1)); tog = 1'b0; end
               6: begin mq.push_back(mk(d, 1'b0, 1'b1));     tog = 1'b0; end
               default: begin mq.push_back(mk(8'hFE, 1'b1, 1'b1)); tog = 1'b0; end
            endcase
         end
      end
      e = mq.pop_front();
      #1;
      chk("octet", bus.tx_octet, e.o);
      chk("is_k",  bus.tx_is_k, e.k);
      chk("even",  bus.tx_even, (slot % 2 == 0));
      chk("ind",   bus.TX_OSET_indicate, e.ind);
      chk("aerr",  bus.align_err, e_aerr);
      slot++;
   endtask

   initial begin
      bus.tx_o_set = 3'd0; bus.TXD = 8'h00; bus.tx_config_reg = 16'h0; bus.rd_pos = 1'b0;

      // 1: reset, held /I/ with rd_pos=0
      do_reset();
      repeat (6) step(3'd0, 8'h00, 16'h0, 1'b0);
      // 2: /I/ with rd_pos=1
      step(3'd0, 8'h00, 16'h0, 1'b1);
      step(3'd0, 8'h00, 16'h0, 1'b0);
      // 3: two /C/ with cfg A1B2
      repeat (8) step(3'd1, 8'h00, 16'hA1B2, 1'b0);
      // 4: S, D x3, T, R, I
      step(3'd2, 8'h00, 16'h0, 1'b0);
      step(3'd6, 8'h01, 16'h0, 1'b0);
      step(3'd6, 8'h02, 16'h0, 1'b0);
      step(3'd6, 8'h03, 16'h0, 1'b0);
      step(3'd3, 8'h00, 16'h0, 1'b0);
      step(3'd4, 8'h00, 16'h0, 1'b0);
      repeat (2) step(3'd0, 8'h00, 16'h0, 1'b0);
      // 5: S then /I/ landing on an odd slot
      step(3'd2, 8'h00, 16'h0, 1'b0);
      repeat (3) step(3'd0, 8'h00, 16'h0, 1'b1);
      // 6: reset during the 3rd code group of /C/
      repeat (3) step(3'd1, 8'h00, 16'h1234, 1'b0);
      do_reset();
      repeat (6) step(3'd1, 8'h00, 16'h5678, 1'b0);

      // random requests, biased towards /I/ and /C/, occasional reset
      for (int i = 0; i < 600; i++) begin
         logic [2:0] os;
         if ($urandom_range(0, 199) == 0) do_reset();
         os = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
         step(os, 8'($urandom), 16'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
